// File: rtl/d_ff_pkg.sv
// rtl/d_ff_pkg.sv - shared types and constants for the D flip-flop input path
package d_ff_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        WAIT_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

    localparam int         DEF_SYNC_STAGES     = 2;
    localparam int         DEF_DEBOUNCE_CYCLES = 8;
    localparam logic [7:0] GLITCH_MAX          = 8'hFF;

    function automatic logic [7:0] glitch_inc(input logic [7:0] v);
        return (v == GLITCH_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/d_sync_chain.sv
// rtl/d_sync_chain.sv - multi-flop synchronizer for a single asynchronous bit
module d_sync_chain import d_ff_pkg::*; #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $fatal(1, "d_sync_chain: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/d_input_debouncer.sv
// rtl/d_input_debouncer.sv - synchronizes and debounces a raw input into a clean d level
module d_input_debouncer import d_ff_pkg::*; #(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    output logic       d_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $fatal(1, "d_input_debouncer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $fatal(1, "d_input_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (CNT_W != $clog2(DEBOUNCE_CYCLES + 1)) begin : g_bad_cnt_w
        $fatal(1, "d_input_debouncer: CNT_W is derived and must not be overridden");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic sync;

    d_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (raw_in),
        .sync_out (sync)
    );

    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [7:0]       glitch_q, glitch_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_out_d  = d_out_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;
        case (state_q)
            ST_LOW: begin
                cnt_d = '0;
                if (sync) begin
                    // a one-cycle qualification window accepts on first sight
                    if (SINGLE) begin
                        state_d = ST_HIGH;
                        d_out_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!sync) begin
                    state_d  = ST_LOW;
                    cnt_d    = '0;
                    glitch_d = glitch_inc(glitch_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    d_out_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                cnt_d = '0;
                if (!sync) begin
                    if (SINGLE) begin
                        state_d = ST_LOW;
                        d_out_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_d  = ST_HIGH;
                    cnt_d    = '0;
                    glitch_d = glitch_inc(glitch_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    d_out_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                d_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            d_out_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_out_q  <= d_out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign d_out      = d_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_d_input_debouncer.sv
// tb/tb_d_input_debouncer.sv - randomized bench for d_input_debouncer against a run-length model
module tb_d_input_debouncer;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       raw_in = 1'b0;
    logic       d_out_a, rise_a, fall_a, busy_a;
    logic [7:0] glitch_a;
    logic       d_out_b, rise_b, fall_b, busy_b;
    logic [7:0] glitch_b;

    always #5 clk = ~clk;

    d_input_debouncer dut_a (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .d_out      (d_out_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .busy       (busy_a),
        .glitch_cnt (glitch_a)
    );

    d_input_debouncer #(
        .DEBOUNCE_CYCLES (1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .d_out      (d_out_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .busy       (busy_b),
        .glitch_cnt (glitch_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: sync is raw delayed SS edges; a new level is accepted after dc
    // consecutive disagreeing samples, and any shorter run is one glitch.
    int  dc[2] = '{8, 1};
    bit  sync_q[$];
    bit  m_lvl[2];
    bit  m_rise[2];
    bit  m_fall[2];
    int  m_run[2];
    int  m_gl[2];
    int  rises_a, rises_b, falls_a, edge_no;

    task automatic model_reset();
        sync_q.delete();
        for (int i = 0; i < SS; i++) sync_q.push_back(1'b0);
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_run[i] = 0; m_gl[i] = 0;
        end
        edge_no = 0;
    endtask

    task automatic model_edge(input bit r);
        bit s;
        s = sync_q.pop_front();
        sync_q.push_back(r);
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (s != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == dc[i]) begin
                    m_lvl[i] = s;
                    m_run[i] = 0;
                    if (s) m_rise[i] = 1; else m_fall[i] = 1;
                end
            end else begin
                if (m_run[i] > 0 && m_gl[i] < 255) m_gl[i]++;
                m_run[i] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec(input int i);
        logic [7:0] g;
        g = m_gl[i][7:0];
        return {20'd0, m_lvl[i], m_rise[i], m_fall[i], (m_run[i] > 0), g};
    endfunction

    task automatic tick(input bit r);
        raw_in = r;
        @(posedge clk);
        model_edge(r);
        edge_no++;
        #1;
        check_eq("outs_dc8", {20'd0, d_out_a, rise_a, fall_a, busy_a, glitch_a}, exp_vec(0));
        check_eq("outs_dc1", {20'd0, d_out_b, rise_b, fall_b, busy_b, glitch_b}, exp_vec(1));
        check_eq("pulse_excl_dc8", {31'd0, rise_a & fall_a}, 32'd0);
        check_eq("busy_dc1_never", {31'd0, busy_b}, 32'd0);
        rises_a += rise_a;
        falls_a += fall_a;
        rises_b += rise_b;
    endtask

    // assert reset a few ns into the cycle, then release it away from an edge
    task automatic apply_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("reset_async_outs", {24'd0, d_out_a, rise_a, fall_a, busy_a, glitch_a[3:0]}, 32'd0);
        check_eq("reset_async_glitch", {24'd0, glitch_a}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int first_a, first_b, g0;
    bit lvl;

    initial begin
        raw_in = 1'b1;
        repeat (2) @(posedge clk);
        apply_reset();

        // raw held high through release: acceptance edge after reset
        first_a = -1; first_b = -1;
        for (int k = 0; k < 14; k++) begin
            tick(1'b1);
            if (d_out_a && first_a < 0) first_a = edge_no;
            if (d_out_b && first_b < 0) first_b = edge_no;
        end
        check_eq("latency_rise_dc8", first_a, 10);
        check_eq("latency_rise_dc1", first_b, 3);

        // abandon a candidate part-way through WAIT_HIGH
        raw_in = 1'b0;
        apply_reset();
        for (int k = 0; k < 7; k++) tick(1'b1);
        check_eq("mid_wait_busy", {31'd0, busy_a}, 32'd1);
        apply_reset();
        check_eq("after_abort_glitch", {24'd0, glitch_a}, 32'd0);

        // clean rise then fall
        for (int k = 0; k < 20; k++) tick(1'b0);
        rises_a = 0; falls_a = 0; first_a = -1; edge_no = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1);
            if (d_out_a && first_a < 0) first_a = edge_no;
        end
        check_eq("clean_rise_edge", first_a, 10);
        check_eq("clean_rise_count", rises_a, 1);
        first_a = -1; edge_no = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0);
            if (!d_out_a && first_a < 0) first_a = edge_no;
        end
        check_eq("clean_fall_edge", first_a, 10);
        check_eq("clean_fall_count", falls_a, 1);

        // bounce: 4 high, 3 low, then settled high
        g0 = glitch_a; rises_a = 0;
        for (int k = 0; k < 4; k++) tick(1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0);
        for (int k = 0; k < 20; k++) tick(1'b1);
        check_eq("bounce_glitch_delta", glitch_a - g0, 1);
        check_eq("bounce_rise_count", rises_a, 1);
        for (int k = 0; k < 20; k++) tick(1'b0);

        // saturation: 300 short high pulses
        rises_a = 0; falls_a = 0;
        for (int p = 0; p < 300; p++) begin
            for (int k = 0; k < 3; k++) tick(1'b1);
            for (int k = 0; k < 4; k++) tick(1'b0);
        end
        check_eq("sat_glitch", {24'd0, glitch_a}, 32'd255);
        check_eq("sat_dout", {31'd0, d_out_a}, 32'd0);
        check_eq("sat_pulses", rises_a + falls_a, 0);

        // DEBOUNCE_CYCLES=1: toggle every 4 cycles
        rises_b = 0;
        lvl = 1'b0;
        for (int t = 0; t < 8; t++) begin
            lvl = ~lvl;
            for (int k = 0; k < 4; k++) tick(lvl);
        end
        check_eq("dc1_rise_count", rises_b, 4);

        // random runs of random level and length
        apply_reset();
        lvl = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            lvl = ($urandom_range(0, 3) != 0) ? ~lvl : lvl;
            len = (seg % 3 == 0) ? $urandom_range(8, 14) : $urandom_range(1, 9);
            for (int k = 0; k < len; k++) tick(lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_input_debouncer.md
# d_input_debouncer

Input-conditioning stage sitting directly upstream of the team's D flip-flop: takes a raw, asynchronous, possibly bouncing single-bit signal and produces a clean, synchronous level (`d_out`) that drives the flip-flop's `d` input. It also emits single-cycle rise/fall pulses and a saturating count of rejected glitches for debug.

## Interface
- `SYNC_STAGES`, 2, synchronizer flop count; legal range ≥2.
- `DEBOUNCE_CYCLES`, 8, consecutive stable synchronized samples required to accept a new level; legal range ≥1.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset; asynchronous assert, active-high.
- `raw_in`  input  1  asynchronous raw input bit.
- `d_out`  output  1  debounced, synchronous level; feeds flip-flop `d`.
- `rise_pulse`  output  1  high for one cycle when `d_out` goes 0→1.
- `fall_pulse`  output  1  high for one cycle when `d_out` goes 1→0.
- `busy`  output  1  high while a candidate transition is being qualified.
- `glitch_cnt`  output  8  saturating count of aborted transitions.

## Operation
- `raw_in` passes through the `SYNC_STAGES`-deep flop chain; the last stage is `sync`.
- FSM states: `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`.
- `ST_LOW`: if `sync`=1 → `WAIT_HIGH`, counter=1; else stay, counter=0.
- `WAIT_HIGH`: if `sync`=1 and counter=`DEBOUNCE_CYCLES`−1 → `ST_HIGH`, `d_out`←1, `rise_pulse`←1, counter=0; if `sync`=1 otherwise → counter+1; if `sync`=0 → `ST_LOW`, counter=0, `glitch_cnt`+1.
- `ST_HIGH` / `WAIT_LOW`: mirror image, with `fall_pulse`.
- With `DEBOUNCE_CYCLES`=1, a `ST_*` state whose `sync` differs from `d_out` transitions directly to the opposite `ST_*`; `WAIT_*` is never entered.
- `busy` = state is `WAIT_HIGH` or `WAIT_LOW` (registered state decode).
- `glitch_cnt` saturates at 255; no wrap.
- Counter never exceeds `DEBOUNCE_CYCLES`−1.
- Pulses are registered and never both high; each lasts exactly one cycle.
- Reset values: sync chain all 0; state `ST_LOW`; counter 0; `d_out` 0; `rise_pulse` 0; `fall_pulse` 0; `busy` 0; `glitch_cnt` 0.
- Reset asserted mid-qualification abandons the candidate. The abandonment does not count as a glitch.

## Timing
- Acceptance latency: with `raw_in` settled before edge E1 and held stable, `d_out` changes on edge E(`SYNC_STAGES`+`DEBOUNCE_CYCLES`). With defaults, that is E10.
- The pulse is asserted on the same edge as the `d_out` change and deasserts on the next edge.
- Sampling of `raw_in` at edges E1..E`SYNC_STAGES` only populates the sync chain; the FSM sees the value on the following edge.
- A single-cycle dip in `sync` during `WAIT_*` restarts qualification. It costs a full `DEBOUNCE_CYCLES` again once `sync` returns.
- Simultaneous glitch abort and `glitch_cnt`=255: state returns to `ST_*`, and the count holds at 255.
- Reset release: the first FSM evaluation occurs on the first rising edge after `rst` deasserts. `raw_in`=1 held through reset release takes the full acceptance latency from that edge.

## Structure
- Shared package `d_ff_pkg`:
  - `deb_state_t` enum (`ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`).
  - Default constants `DEF_SYNC_STAGES`=2 and `DEF_DEBOUNCE_CYCLES`=8.
  - `GLITCH_MAX`=8'hFF.
- One sub-module, `d_sync_chain`:
  - Parameterized `SYNC_STAGES` flop chain.
  - Async active-high reset to 0.
  - Ports `clk`, `rst`, `async_in`, `sync_out`.
  - Reused elsewhere for other async inputs.
- Parameter legality is checked at elaboration; illegal values are a fatal error.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle with `raw_in`=1 → all outputs 0 immediately. `d_out` rises 10 edges after release (defaults).
- Clean rise/fall: drive `raw_in` 0→1 and hold 20 cycles → `d_out`=1 on E10, `rise_pulse` high for exactly 1 cycle. Then 1→0 → `d_out`=0 after 10 edges, single `fall_pulse`.
- Bounce rejection: 1 for 4 cycles, 0 for 3, 1 held → one glitch counted (`glitch_cnt`=1). `d_out` rises 8 FSM-edges after the final stable `sync`=1, with exactly one `rise_pulse`.
- Glitch saturation: 300 pulses of 3 cycles each, spaced by 4 low cycles → `glitch_cnt`=255, `d_out` stays 0, no pulses.
- Reset mid-`WAIT_HIGH`: assert `rst` at counter=5 → state `ST_LOW`, `busy`=0, `glitch_cnt` unchanged at 0.
- `DEBOUNCE_CYCLES`=1 build: toggle `raw_in` every 4 cycles → `d_out` follows with a 3-edge latency, one pulse per transition, `busy` never asserted.
